// File: rtl/serial_addsub.sv
// Chunk-serial adder/subtractor: processes Chunk bits per clock, LSB first, with a
// registered inter-chunk carry and an optional accumulator feeding operand A.
module serial_addsub #(
  parameter int unsigned Size  = 8,
  parameter int unsigned Chunk = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            mode,
  input  logic            acc_en,
  input  logic            acc_clr,
  input  logic [Size-1:0] A,
  input  logic [Size-1:0] B,
  input  logic            cin,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [Size-1:0] S,
  output logic            cout,
  output logic            ovf,
  output logic            zero
);

  localparam int unsigned N    = Size / Chunk;
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(N - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            r_state;
  logic [IdxW-1:0]   r_idx;
  logic              r_carry;
  logic [Size-1:0]   r_a;
  logic [Size-1:0]   r_b;      // B already inverted for subtract
  logic [Size-1:0]   r_work;
  logic [Size-1:0]   r_acc;
  logic [Size-1:0]   r_s;
  logic              r_cout;
  logic              r_ovf;
  logic              r_zero;

  logic [Chunk-1:0]  w_a_chunk;
  logic [Chunk-1:0]  w_b_chunk;
  logic [Chunk:0]    w_sum;
  logic [Size-1:0]   w_res;
  logic              w_last;
  logic              w_ovf;

  always_comb begin
    w_a_chunk = r_a[r_idx*Chunk +: Chunk];
    w_b_chunk = r_b[r_idx*Chunk +: Chunk];
    w_sum     = {1'b0, w_a_chunk} + {1'b0, w_b_chunk} + {{Chunk{1'b0}}, r_carry};
    w_res     = r_work;
    w_res[r_idx*Chunk +: Chunk] = w_sum[Chunk-1:0];
    w_last    = (r_idx == LastIdx);
    // With B pre-inverted, add and subtract share one overflow rule
    w_ovf     = (r_a[Size-1] == r_b[Size-1]) && (w_res[Size-1] != r_a[Size-1]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_work  <= '0;
      r_acc   <= '0;
      r_s     <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_zero  <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (acc_clr) begin
            r_acc <= '0;
          end
          if (in_valid) begin
            if (acc_en) begin
              r_a <= acc_clr ? '0 : r_acc;
            end else begin
              r_a <= A;
            end
            r_b     <= mode ? ~B : B;
            r_carry <= mode ? 1'b1 : cin;
            r_idx   <= '0;
            r_work  <= '0;
            r_state <= StRun;
          end
        end
        StRun: begin
          r_work  <= w_res;
          r_carry <= w_sum[Chunk];
          if (w_last) begin
            r_s     <= w_res;
            r_cout  <= w_sum[Chunk];
            r_ovf   <= w_ovf;
            r_zero  <= (w_res == '0);
            r_state <= StDone;
          end else begin
            r_idx <= r_idx + IdxW'(1);
          end
        end
        StDone: begin
          if (out_ready) begin
            r_acc   <= r_s;
            r_state <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign in_ready  = (r_state == StIdle);
  assign out_valid = (r_state == StDone);
  assign S         = r_s;
  assign cout      = r_cout;
  assign ovf       = r_ovf;
  assign zero      = r_zero;

endmodule

// File: tb/tb_serial_addsub.sv
// Directed bench for serial_addsub (Size=8, Chunk=2): scoreboard of expected results
// checked with immediate assertions when out_valid rises.
module tb_serial_addsub;

  typedef struct packed {
    logic [7:0] s;
    logic       cout;
    logic       ovf;
    logic       zero;
  } res_t;

  logic       clk = 1'b0;
  logic       rst, in_valid, in_ready, mode, acc_en, acc_clr, cin;
  logic       out_valid, out_ready, cout, ovf, zero;
  logic [7:0] A, B, S;

  res_t       sb[$];
  int         n_assert = 0;
  int         n_fail = 0;
  logic [7:0] acc_model;

  serial_addsub #(.Size(8), .Chunk(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
    .acc_en(acc_en), .acc_clr(acc_clr), .A(A), .B(B), .cin(cin), .out_valid(out_valid),
    .out_ready(out_ready), .S(S), .cout(cout), .ovf(ovf), .zero(zero)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: observed no end of test, required end before 200000");
    $fatal(1, "timeout");
  end

  function automatic res_t mk(input logic [7:0] s, input logic c, input logic o, input logic z);
    res_t r;
    r.s = s; r.cout = c; r.ovf = o; r.zero = z;
    return r;
  endfunction

  function automatic res_t model(input logic m, input logic [7:0] a, input logic [7:0] b,
                                 input logic c);
    logic [8:0] t;
    res_t r;
    if (m) t = {1'b0, a} - {1'b0, b};
    else   t = {1'b0, a} + {1'b0, b} + {8'd0, c};
    r.s    = t[7:0];
    r.cout = m ? (a >= b) : t[8];
    r.ovf  = m ? ((a[7] != b[7]) && (r.s[7] != a[7])) : ((a[7] == b[7]) && (r.s[7] != a[7]));
    r.zero = (r.s == 8'd0);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_result(input res_t e);
    chk("S", 32'(S), 32'(e.s));
    chk("cout", 32'(cout), 32'(e.cout));
    chk("ovf", 32'(ovf), 32'(e.ovf));
    chk("zero", 32'(zero), 32'(e.zero));
  endtask

  task automatic run_op(input logic m, input logic ae, input logic ac, input logic [7:0] a,
                        input logic [7:0] b, input logic c, input logic use_k, input res_t k);
    logic [7:0] opa;
    logic [7:0] s_prev;
    res_t       e;
    int         lat;
    opa = ae ? (ac ? 8'h00 : acc_model) : a;
    e   = use_k ? k : model(m, opa, b, c);
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    s_prev = S;
    mode = m; acc_en = ae; acc_clr = ac; A = a; B = b; cin = c; in_valid = 1'b1;
    sb.push_back(e);
    tick;
    in_valid = 1'b0; acc_en = 1'b0; acc_clr = 1'b0;
    chk("S_held_in_run", 32'(S), 32'(s_prev));
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick;
      lat++;
    end
    chk("latency", 32'(lat), 32'd4);
    e = sb.pop_front();
    chk_result(e);
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    chk("in_ready_after_release", 32'(in_ready), 32'd1);
    chk("out_valid_after_release", 32'(out_valid), 32'd0);
    chk("S_retained_idle", 32'(S), 32'(e.s));
    acc_model = e.s;
  endtask

  initial begin
    res_t e;
    int   lat;
    logic seen;
    rst = 1'b1; in_valid = 1'b0; mode = 1'b0; acc_en = 1'b0; acc_clr = 1'b0;
    cin = 1'b0; out_ready = 1'b0; A = 8'h00; B = 8'h00; acc_model = 8'h00;
    tick;
    tick;
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk_result(mk(8'h00, 1'b0, 1'b0, 1'b0));
    rst = 1'b0;
    tick;

    // Fixed vectors
    run_op(1'b0, 1'b0, 1'b0, 8'h7F, 8'h01, 1'b0, 1'b1, mk(8'h80, 1'b0, 1'b1, 1'b0));
    run_op(1'b1, 1'b0, 1'b0, 8'h05, 8'h05, 1'b0, 1'b1, mk(8'h00, 1'b1, 1'b0, 1'b1));
    run_op(1'b1, 1'b0, 1'b0, 8'h00, 8'h01, 1'b0, 1'b1, mk(8'hFF, 1'b0, 1'b0, 1'b0));
    run_op(1'b1, 1'b0, 1'b0, 8'h00, 8'h01, 1'b1, 1'b1, mk(8'hFF, 1'b0, 1'b0, 1'b0));
    run_op(1'b0, 1'b0, 1'b0, 8'hFF, 8'h00, 1'b1, 1'b1, mk(8'h00, 1'b1, 1'b0, 1'b1));

    // Accumulator chain
    acc_clr = 1'b1;
    tick;
    acc_clr = 1'b0;
    acc_model = 8'h00;
    run_op(1'b0, 1'b1, 1'b0, 8'hAA, 8'h10, 1'b0, 1'b1, mk(8'h10, 1'b0, 1'b0, 1'b0));
    run_op(1'b0, 1'b1, 1'b0, 8'hAA, 8'h10, 1'b0, 1'b1, mk(8'h20, 1'b0, 1'b0, 1'b0));
    run_op(1'b0, 1'b1, 1'b0, 8'hAA, 8'h10, 1'b0, 1'b1, mk(8'h30, 1'b0, 1'b0, 1'b0));
    run_op(1'b0, 1'b1, 1'b1, 8'hAA, 8'h03, 1'b0, 1'b1, mk(8'h03, 1'b0, 1'b0, 1'b0));

    // Random operands against the reference model
    for (int i = 0; i < 6; i++) begin
      run_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 8'($urandom),
             8'($urandom), 1'($urandom_range(0, 1)), 1'b0, mk(8'h00, 1'b0, 1'b0, 1'b0));
    end

    // Back-pressure in DONE; in_valid and acc_clr there must be ignored
    mode = 1'b0; A = 8'h12; B = 8'h34; cin = 1'b0; in_valid = 1'b1;
    sb.push_back(model(1'b0, 8'h12, 8'h34, 1'b0));
    tick;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick;
      lat++;
    end
    chk("hold_latency", 32'(lat), 32'd4);
    e = sb.pop_front();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; acc_clr = 1'b1; A = 8'h01; B = 8'h01;
      tick;
      chk("hold_S", 32'(S), 32'(e.s));
      chk("hold_out_valid", 32'(out_valid), 32'd1);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0; acc_clr = 1'b0; out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    chk("hold_release_in_ready", 32'(in_ready), 32'd1);
    acc_model = e.s;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick;
      seen = seen | out_valid;
    end
    chk("no_phantom_op", 32'(seen), 32'd0);
    run_op(1'b0, 1'b1, 1'b0, 8'h00, 8'h01, 1'b0, 1'b1, mk(8'h47, 1'b0, 1'b0, 1'b0));

    // Reset in the middle of RUN (before chunk 2 is processed)
    mode = 1'b0; A = 8'h5A; B = 8'h21; cin = 1'b0; in_valid = 1'b1;
    sb.push_back(model(1'b0, 8'h5A, 8'h21, 1'b0));
    tick;
    in_valid = 1'b0;
    tick;
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    sb.delete();
    acc_model = 8'h00;
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk_result(mk(8'h00, 1'b0, 1'b0, 1'b0));
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick;
      seen = seen | out_valid;
    end
    chk("abort_no_out_valid", 32'(seen), 32'd0);
    run_op(1'b0, 1'b1, 1'b0, 8'hEE, 8'h07, 1'b0, 1'b1, mk(8'h07, 1'b0, 1'b0, 1'b0));
    run_op(1'b1, 1'b0, 1'b0, 8'h80, 8'h01, 1'b0, 1'b1, mk(8'h7F, 1'b1, 1'b1, 1'b0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
